// File: rtl/amstrad_mem_arbiter.sv
// amstrad_mem_arbiter
// Shares one byte-wide memory port among three requesters: video fetch,
// CPU and a loader/DMA engine. Fixed priority VID > CPU > DMA, except
// that after STARVE consecutive VID/CPU grants made while DMA was waiting,
// a pending DMA request wins outright.
//
// state | meaning
// IDLE  | no transaction outstanding; a grant is made here on any request
// BUSY  | ram_req asserted for the owner, waiting for ram_ack
//
// Ports
//   clk, reset_n                  clock, async active-low reset
//   vid_req/addr, vid_ack/rdata   video read channel
//   cpu_req/we/addr/wdata         CPU channel, cpu_ack/cpu_rdata back
//   dma_req/we/addr/wdata         DMA channel, dma_ack/dma_rdata back
//   ram_req/we/addr/wdata         memory request, held until ram_ack
//   ram_rdata, ram_ack            memory response
module amstrad_mem_arbiter #(
    parameter int AW     = 23,
    parameter int STARVE = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic          vid_ack,
    output logic [7:0]    vid_rdata,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic          cpu_ack,
    output logic [7:0]    cpu_rdata,
    input  logic          dma_req,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [7:0]    dma_wdata,
    output logic          dma_ack,
    output logic [7:0]    dma_rdata,
    output logic          ram_req,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata,
    input  logic          ram_ack
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_BUSY = 1'b1;

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_VID  = 2'd1;
    localparam logic [1:0] OWN_CPU  = 2'd2;
    localparam logic [1:0] OWN_DMA  = 2'd3;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE);

    logic [0:0] state;
    logic [1:0] owner;
    logic [3:0] starve_cnt;
    logic [1:0] winner;

    // Winner is only acted on in IDLE; it is don't-care while BUSY.
    always_comb begin
        winner = OWN_NONE;
        if (dma_req && (starve_cnt == STARVE_MAX)) winner = OWN_DMA;
        else if (vid_req)                          winner = OWN_VID;
        else if (cpu_req)                          winner = OWN_CPU;
        else if (dma_req)                          winner = OWN_DMA;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            owner      <= OWN_NONE;
            starve_cnt <= 4'd0;
            ram_req    <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= 8'h00;
            vid_ack    <= 1'b0;
            cpu_ack    <= 1'b0;
            dma_ack    <= 1'b0;
            vid_rdata  <= 8'h00;
            cpu_rdata  <= 8'h00;
            dma_rdata  <= 8'h00;
        end else begin
            vid_ack <= 1'b0;
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (winner != OWN_NONE) begin
                        state   <= ST_BUSY;
                        owner   <= winner;
                        ram_req <= 1'b1;
                        case (winner)
                            OWN_VID: begin
                                ram_addr  <= vid_addr;
                                ram_we    <= 1'b0;
                                ram_wdata <= 8'h00;
                            end
                            OWN_CPU: begin
                                ram_addr  <= cpu_addr;
                                ram_we    <= cpu_we;
                                ram_wdata <= cpu_wdata;
                            end
                            default: begin
                                ram_addr  <= dma_addr;
                                ram_we    <= dma_we;
                                ram_wdata <= dma_wdata;
                            end
                        endcase
                        // Only grants that bypass a waiting DMA count toward starvation.
                        if (winner == OWN_DMA) begin
                            starve_cnt <= 4'd0;
                        end else if (dma_req && (starve_cnt != STARVE_MAX)) begin
                            starve_cnt <= starve_cnt + 4'd1;
                        end
                    end
                end
                ST_BUSY: begin
                    if (ram_ack) begin
                        state   <= ST_IDLE;
                        owner   <= OWN_NONE;
                        ram_req <= 1'b0;
                        case (owner)
                            OWN_VID: begin
                                vid_ack <= 1'b1;
                                if (!ram_we) vid_rdata <= ram_rdata;
                            end
                            OWN_CPU: begin
                                cpu_ack <= 1'b1;
                                if (!ram_we) cpu_rdata <= ram_rdata;
                            end
                            OWN_DMA: begin
                                dma_ack <= 1'b1;
                                if (!ram_we) dma_rdata <= ram_rdata;
                            end
                            default: ;
                        endcase
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_amstrad_mem_arbiter.sv
module tb_amstrad_mem_arbiter;

    localparam int AW = 23;

    logic          clk;
    logic          reset_n;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic          vid_ack;
    logic [7:0]    vid_rdata;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata;
    logic          cpu_ack;
    logic [7:0]    cpu_rdata;
    logic          dma_req;
    logic          dma_we;
    logic [AW-1:0] dma_addr;
    logic [7:0]    dma_wdata;
    logic          dma_ack;
    logic [7:0]    dma_rdata;
    logic          ram_req;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata;
    logic          ram_ack;

    int checks = 0;
    int errors = 0;

    amstrad_mem_arbiter #(.AW(AW), .STARVE(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack), .vid_rdata(vid_rdata),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_ack(dma_ack), .dma_rdata(dma_rdata),
        .ram_req(ram_req), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ack(ram_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ack_count();
        return 32'(vid_ack) + 32'(cpu_ack) + 32'(dma_ack);
    endfunction

    // Waits (bounded) for ram_req, checks the latched request, answers after
    // lat cycles of ram_req high, and returns at the cycle the *_ack is visible.
    task automatic serve(input string tag, input logic [AW-1:0] exp_addr, input logic exp_we,
                         input logic [7:0] exp_wd, input int lat, input logic [7:0] rd,
                         output int waits);
        waits = 0;
        while (!ram_req && waits < 20) begin
            tick();
            waits++;
        end
        check({tag, " ram_req"}, 32'(ram_req), 32'd1);
        check({tag, " ram_addr"}, 32'(ram_addr), 32'(exp_addr));
        check({tag, " ram_we"}, 32'(ram_we), 32'(exp_we));
        check({tag, " ram_wdata"}, 32'(ram_wdata), 32'(exp_wd));
        for (int i = 1; i < lat; i++) tick();
        ram_rdata = rd;
        ram_ack   = 1'b1;
        tick();
        ram_ack   = 1'b0;
        check({tag, " ram_req drop"}, 32'(ram_req), 32'd0);
        check({tag, " one ack"}, ack_count(), 32'd1);
    endtask

    initial begin
        int w;
        int hi;
        logic [AW-1:0] keep_addr;

        reset_n = 1'b0;
        vid_req = 0; vid_addr = '0;
        cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = 8'h00;
        dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = 8'h00;
        ram_rdata = 8'h00; ram_ack = 1'b0;

        // Reset state
        #12;
        check("rst ram_req", 32'(ram_req), 32'd0);
        check("rst ram_addr", 32'(ram_addr), 32'd0);
        check("rst ram_we", 32'(ram_we), 32'd0);
        check("rst acks", ack_count(), 32'd0);
        check("rst rdata", {8'h00, vid_rdata, cpu_rdata, dma_rdata}, 32'd0);
        check("rst starve", 32'(dut.starve_cnt), 32'd0);
        tick();
        reset_n = 1'b1;
        tick();

        // CPU read, three cycles of ram_req
        cpu_req = 1; cpu_we = 0; cpu_addr = 23'h004000;
        tick();
        check("cpu rd addr", 32'(ram_addr), 32'h004000);
        hi = 0;
        for (int i = 0; i < 3; i++) begin
            if (ram_req) hi++;
            if (i == 2) begin ram_rdata = 8'h5A; ram_ack = 1; end
            else tick();
        end
        tick();
        ram_ack = 0;
        cpu_req = 0;
        check("cpu rd req cycles", 32'(hi), 32'd3);
        check("cpu rd req low", 32'(ram_req), 32'd0);
        check("cpu rd ack", 32'(cpu_ack), 32'd1);
        check("cpu rd data", 32'(cpu_rdata), 32'h5A);
        tick();
        check("cpu rd ack pulse", 32'(cpu_ack), 32'd0);

        // Simultaneous requests: VID, CPU, DMA in order
        vid_req = 1; vid_addr = 23'h000100;
        cpu_req = 1; cpu_addr = 23'h000200; cpu_wdata = 8'h00;
        dma_req = 1; dma_addr = 23'h000300; dma_we = 0; dma_wdata = 8'h00;
        serve("pri vid", 23'h000100, 1'b0, 8'h00, 2, 8'h11, w);
        check("pri vid ack", 32'(vid_ack), 32'd1);
        check("pri vid data", 32'(vid_rdata), 32'h11);
        check("pri starve after vid", 32'(dut.starve_cnt), 32'd1);
        vid_req = 0;
        serve("pri cpu", 23'h000200, 1'b0, 8'h00, 1, 8'h22, w);
        check("pri cpu ack", 32'(cpu_ack), 32'd1);
        check("pri cpu data", 32'(cpu_rdata), 32'h22);
        check("pri starve after cpu", 32'(dut.starve_cnt), 32'd2);
        cpu_req = 0;
        serve("pri dma", 23'h000300, 1'b0, 8'h00, 1, 8'h33, w);
        check("pri dma ack", 32'(dma_ack), 32'd1);
        check("pri dma data", 32'(dma_rdata), 32'h33);
        check("pri starve after dma", 32'(dut.starve_cnt), 32'd0);
        check("pri vid data held", 32'(vid_rdata), 32'h11);
        dma_req = 0;
        tick();

        // Starvation: four VID grants, then DMA wins
        vid_req = 1; vid_addr = 23'h000400;
        cpu_req = 1; cpu_addr = 23'h000500;
        dma_req = 1; dma_addr = 23'h000600;
        for (int k = 0; k < 4; k++) begin
            serve("stv vid", 23'h000400, 1'b0, 8'h00, 1, 8'(8'h40 + k), w);
            check("stv vid ack", 32'(vid_ack), 32'd1);
        end
        check("stv count at max", 32'(dut.starve_cnt), 32'd4);
        serve("stv dma", 23'h000600, 1'b0, 8'h00, 1, 8'h44, w);
        check("stv gap", 32'(w), 32'd1);
        check("stv dma ack", 32'(dma_ack), 32'd1);
        check("stv count cleared", 32'(dut.starve_cnt), 32'd0);
        vid_req = 0; cpu_req = 0; dma_req = 0;
        tick();

        // DMA write at top address with CPU inputs toggling
        dma_req = 1; dma_we = 1; dma_addr = 23'h7FFFFF; dma_wdata = 8'hC3;
        tick();
        check("dwr req", 32'(ram_req), 32'd1);
        keep_addr = 23'h001234;
        for (int k = 0; k < 3; k++) begin
            cpu_addr = keep_addr ^ 23'(k * 23'h0F0F0F);
            cpu_wdata = 8'(k);
            check("dwr addr stable", 32'(ram_addr), 32'h7FFFFF);
            check("dwr we stable", 32'(ram_we), 32'd1);
            check("dwr wdata stable", 32'(ram_wdata), 32'hC3);
            tick();
        end
        ram_rdata = 8'hEE; ram_ack = 1;
        tick();
        ram_ack = 0; dma_req = 0; dma_we = 0;
        check("dwr ack", 32'(dma_ack), 32'd1);
        check("dwr rdata kept", 32'(dma_rdata), 32'h44);
        tick();

        // Spurious ram_ack while idle
        ram_rdata = 8'h77; ram_ack = 1;
        tick();
        ram_ack = 0;
        check("spur acks", ack_count(), 32'd0);
        check("spur state", 32'(dut.state), 32'd0);
        check("spur ram_req", 32'(ram_req), 32'd0);
        tick();
        check("spur acks later", ack_count(), 32'd0);

        // Requester drops during BUSY: still completes
        cpu_req = 1; cpu_we = 1; cpu_addr = 23'h002000; cpu_wdata = 8'hA5;
        tick();
        cpu_req = 0;
        serve("drop cpu", 23'h002000, 1'b1, 8'hA5, 2, 8'h66, w);
        check("drop cpu ack", 32'(cpu_ack), 32'd1);
        check("drop cpu rdata kept", 32'(cpu_rdata), 32'h22);
        cpu_we = 0;
        tick();

        // Reset during BUSY, then normal completion
        cpu_req = 1; cpu_addr = 23'h000123;
        tick();
        check("rbusy req", 32'(ram_req), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rbusy req cleared", 32'(ram_req), 32'd0);
        check("rbusy state", 32'(dut.state), 32'd0);
        check("rbusy cpu_rdata", 32'(cpu_rdata), 32'd0);
        ram_ack = 1;
        tick();
        ram_ack = 0;
        check("rbusy no ack", ack_count(), 32'd0);
        reset_n = 1'b1;
        serve("rbusy cpu", 23'h000123, 1'b0, 8'hA5, 1, 8'h99, w);
        check("rbusy gap", 32'(w), 32'd1);
        check("rbusy cpu ack", 32'(cpu_ack), 32'd1);
        check("rbusy cpu data", 32'(cpu_rdata), 32'h99);
        cpu_req = 0;
        tick();
        check("rbusy ack pulse", 32'(cpu_ack), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
